oam_dma_stage: RTL and testbench

//  Sits on the MMU port of the CPU-side address splitter, between it and the main MMU.

---
 rtl/oam_dma_stage.sv | 167 ++++++++++++++++
 tb/tb_oam_dma_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_stage.sv
// oam_dma_stage: OAM DMA engine sitting on the CPU-to-MMU path.
// Owns register FF46. A write to it copies DMA_LEN bytes from {src,8'h00}
// into OAM, reading through the downstream MMU bus. While the copy runs the
// CPU is locked off the downstream bus. When idle, CPU traffic passes
// straight through.
//
// Optional feature macro: OAM_DMA_ECHO_FOLD_EN
//   defined   : sources E0-FF fold down by 8'h20 (echo RAM -> C000-DFFF)
//   undefined : source page used as written
// FF46 always reads back the raw value written.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | pass-through, waiting for a write to FF46
// S_START  | one cycle set-up after an FF46 write; idx/phase cleared
// S_ACTIVE | copying; one byte every CYCLES_PER_BYTE cycles
module oam_dma_stage #(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int DMA_LEN         = 160
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A_up,
  input  logic [7:0]  Di_up,
  output logic [7:0]  Do_up,
  input  logic        cs_up,
  input  logic        wr_up,
  input  logic        rd_up,
  output logic [15:0] A_down,
  output logic [7:0]  Do_down,
  input  logic [7:0]  Di_down,
  output logic        cs_down,
  output logic        wr_down,
  output logic        rd_down,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_wr,
  output logic        dma_active
);

  localparam int             PW       = $clog2(CYCLES_PER_BYTE);
  localparam logic [PW-1:0]  PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0]     IDX_LAST = 8'(DMA_LEN - 1);
  localparam logic [15:0]    REG_ADDR = 16'hFF46;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     src_q, src_d;
  logic [7:0]     idx_q, idx_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [7:0]     src_eff;
  logic           reg_hit;

  assign reg_hit    = cs_up && (A_up == REG_ADDR);
  assign dma_active = (state_q != S_IDLE);

  // Effective source page used on the downstream bus.
  always_comb begin
`ifdef OAM_DMA_ECHO_FOLD_EN
    src_eff = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;
`else
    src_eff = src_q;
`endif
  end

  // State, source register, byte index and phase counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= 8'h00;
      idx_q   <= 8'h00;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic, bus steering and OAM write generation.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    idx_d    = idx_q;
    phase_d  = phase_q;
    A_down   = 16'h0000;
    Do_down  = 8'h00;
    cs_down  = 1'b0;
    wr_down  = 1'b0;
    rd_down  = 1'b0;
    Do_up    = 8'hFF;
    oam_wr   = 1'b0;
    oam_addr = 8'h00;
    oam_data = 8'h00;

    case (state_q)
      S_IDLE: begin
        A_down  = A_up;
        Do_down = Di_up;
        cs_down = cs_up;
        wr_down = wr_up;
        rd_down = rd_up;
        Do_up   = Di_down;
        if (reg_hit && wr_up) begin
          src_d   = Di_up;
          state_d = S_START;
        end
      end

      S_START: begin
        A_down  = {src_eff, 8'h00};
        idx_d   = 8'h00;
        phase_d = '0;
        state_d = S_ACTIVE;
      end

      S_ACTIVE: begin
        A_down  = {src_eff, idx_q};
        cs_down = 1'b1;
        rd_down = 1'b1;
        if (phase_q == PH_LAST) begin
          oam_wr   = 1'b1;
          oam_addr = idx_q;
          oam_data = Di_down;
          phase_d  = '0;
          if (idx_q == IDX_LAST) begin
            idx_d   = 8'h00;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // FF46 is local: never forwarded, always readable, and a write while
    // busy restarts the copy. A byte write already due this cycle still
    // goes out above with the old source.
    if (reg_hit) begin
      cs_down = 1'b0;
      wr_down = 1'b0;
      rd_down = 1'b0;
      if (rd_up) begin
        Do_up = src_q;
      end
      if (wr_up && (state_q != S_IDLE)) begin
        src_d   = Di_up;
        state_d = S_START;
        idx_d   = 8'h00;
        phase_d = '0;
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_stage.sv
// Scoreboard bench for oam_dma_stage: expected OAM writes are queued when a
// copy is started; a monitor pops and compares on every oam_wr pulse.
module tb_oam_dma_stage;

  logic        clk;
  logic        rst_n;
  logic [15:0] A_up;
  logic [7:0]  Di_up;
  logic [7:0]  Do_up;
  logic        cs_up, wr_up, rd_up;
  logic [15:0] A_down;
  logic [7:0]  Do_down;
  logic [7:0]  Di_down;
  logic        cs_down, wr_down, rd_down;
  logic [7:0]  oam_addr, oam_data;
  logic        oam_wr, dma_active;

  logic        pre_we;
  logic [15:0] pre_a;
  logic [7:0]  pre_d;
  logic [7:0]  mem [65536];

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  idx;
    logic [7:0]  d;
  } exp_t;

  exp_t sb[$];
  exp_t e;

`ifdef OAM_DMA_ECHO_FOLD_EN
  localparam logic [7:0] ECHO_HI  = 8'hC2;
  localparam logic [7:0] ECHO_KEY = 8'h33;
`else
  localparam logic [7:0] ECHO_HI  = 8'hE2;
  localparam logic [7:0] ECHO_KEY = 8'hC6;
`endif

  oam_dma_stage #(.CYCLES_PER_BYTE(4), .DMA_LEN(160)) dut (
    .clk(clk), .rst_n(rst_n),
    .A_up(A_up), .Di_up(Di_up), .Do_up(Do_up),
    .cs_up(cs_up), .wr_up(wr_up), .rd_up(rd_up),
    .A_down(A_down), .Do_down(Do_down), .Di_down(Di_down),
    .cs_down(cs_down), .wr_down(wr_down), .rd_down(rd_down),
    .oam_addr(oam_addr), .oam_data(oam_data), .oam_wr(oam_wr),
    .dma_active(dma_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream memory: combinational read, clocked write.
  assign Di_down = mem[A_down];
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (cs_down && wr_down) mem[A_down] <= Do_down;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // Monitor: every OAM write must match the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (oam_wr) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_oam_wr addr=%0h data=%0h", oam_addr, oam_data);
      end else begin
        e = sb.pop_front();
        check("oam_addr", {24'h0, oam_addr}, {24'h0, e.idx});
        check("oam_data", {24'h0, oam_data}, {24'h0, e.d});
        check("dma_a_down", {16'h0, A_down}, {16'h0, e.a});
      end
    end else if (rst_n) begin
      check("oam_idle_zero", {16'h0, oam_addr, oam_data}, 32'h0);
    end
  end

  task automatic push_copy(input logic [7:0] hi, input int n, input logic [7:0] key);
    for (int i = 0; i < n; i++) begin
      sb.push_back({hi, 8'(i), 8'(i), 8'(i) ^ key});
    end
  endtask

  task automatic preload(input logic [7:0] hi, input logic [7:0] key);
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      pre_we = 1'b1;
      pre_a  = {hi, 8'(i)};
      pre_d  = 8'(i) ^ key;
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    A_up = a; Di_up = d; cs_up = 1'b1; wr_up = 1'b1; rd_up = 1'b0;
    @(negedge clk);
    cs_up = 1'b0; wr_up = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d,
                          output logic [15:0] ad, output logic cs_d, output logic rd_d);
    @(negedge clk);
    A_up = a; cs_up = 1'b1; rd_up = 1'b1; wr_up = 1'b0;
    #1;
    d = Do_up; ad = A_down; cs_d = cs_down; rd_d = rd_down;
    @(negedge clk);
    cs_up = 1'b0; rd_up = 1'b0;
  endtask

  task automatic run_to_idle(input int start, output int n);
    n = start;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!dma_active) return;
      n++;
    end
    timeout("run_to_idle");
  endtask

  task automatic wait_pulse(input logic [7:0] a);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (oam_wr && oam_addr == a) return;
    end
    timeout("wait_pulse");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [7:0]  rd;
    logic [15:0] ad;
    logic        csd, rdd;

    rst_n = 1'b0;
    A_up = 16'h0000; Di_up = 8'h00; cs_up = 1'b0; wr_up = 1'b0; rd_up = 1'b0;
    pre_we = 1'b0; pre_a = 16'h0000; pre_d = 8'h00;
    #2;
    check("rst_oam_wr", oam_wr, 1'b0);
    check("rst_dma_active", dma_active, 1'b0);
    check("rst_cs_down", cs_down, 1'b0);
    A_up = 16'h1234; cs_up = 1'b1; rd_up = 1'b1;
    #1;
    check("rst_pass_a", A_down, 16'h1234);
    check("rst_pass_rd", {cs_down, rd_down, wr_down}, 3'b110);
    cs_up = 1'b0; rd_up = 1'b0;

    preload(8'hC1, 8'h5A);
    preload(8'hD0, 8'hA5);
    preload(8'hC2, 8'h33);
    preload(8'hE2, 8'hC6);
    @(negedge clk);
    pre_we = 1'b1; pre_a = 16'hC000; pre_d = 8'h3C;
    @(negedge clk);
    pre_we = 1'b0;
    rst_n = 1'b1;

    cpu_read(16'hFF46, rd, ad, csd, rdd);
    check("rst_ff46", rd, 8'h00);
    check("ff46_not_fwd", {csd, rdd}, 2'b00);

    // Full copy from C100 with first-byte timing.
    push_copy(8'hC1, 160, 8'h5A);
    cpu_write(16'hFF46, 8'hC1);
    check("t2_start_active", dma_active, 1'b1);
    check("t2_start_no_wr", oam_wr, 1'b0);
    n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n++;
      check("t2_early_wr", oam_wr, 1'b0);
    end
    @(negedge clk);
    n++;
    check("t2_first_wr", oam_wr, 1'b1);
    check("t2_first_addr", oam_addr, 8'h00);
    check("t2_first_a_down", A_down, 16'hC100);
    run_to_idle(n, n);
    check("t1_active_cycles", n, 641);
    check("t1_sb_empty", sb.size(), 0);
    check("t1_pulses", pulses, 160);

    // CPU locked out mid-copy.
    push_copy(8'hC1, 160, 8'h5A);
    cpu_write(16'hFF46, 8'hC1);
    repeat (20) @(negedge clk);
    cpu_read(16'hC000, rd, ad, csd, rdd);
    check("t3_read_ff", rd, 8'hFF);
    check("t3_read_not_fwd", ad[15:8], 8'hC1);
    @(negedge clk);
    A_up = 16'hC000; Di_up = 8'h77; cs_up = 1'b1; wr_up = 1'b1;
    #1;
    check("t3_wr_not_fwd", wr_down, 1'b0);
    check("t3_wr_a_down", A_down[15:8], 8'hC1);
    @(negedge clk);
    cs_up = 1'b0; wr_up = 1'b0;
    run_to_idle(0, n);
    check("t3_sb_empty", sb.size(), 0);
    cpu_read(16'hC000, rd, ad, csd, rdd);
    check("t3_mem_unchanged", rd, 8'h3C);
    check("t3_idle_pass", {ad, csd, rdd}, {16'hC000, 2'b11});

    // Restart at idx 50.
    push_copy(8'hC1, 50, 8'h5A);
    cpu_write(16'hFF46, 8'hC1);
    wait_pulse(8'd49);
    check("t4_first50", sb.size(), 0);
    push_copy(8'hD0, 160, 8'hA5);
    cpu_write(16'hFF46, 8'hD0);
    check("t4_start_active", dma_active, 1'b1);
    check("t4_start_no_wr", oam_wr, 1'b0);
    check("t4_start_no_cs", cs_down, 1'b0);
    @(negedge clk);
    check("t4_next_a_down", A_down, 16'hD000);
    check("t4_next_cs_rd", {cs_down, rd_down}, 2'b11);
    run_to_idle(2, n);
    check("t4_active_cycles", n, 641);
    check("t4_sb_empty", sb.size(), 0);

    // Echo-page source.
    push_copy(ECHO_HI, 160, ECHO_KEY);
    cpu_write(16'hFF46, 8'hE2);
    repeat (10) @(negedge clk);
    cpu_read(16'hFF46, rd, ad, csd, rdd);
    check("t5_ff46_busy", rd, 8'hE2);
    check("t5_ff46_not_fwd", {csd, rdd}, 2'b00);
    run_to_idle(0, n);
    check("t5_sb_empty", sb.size(), 0);
    cpu_read(16'hFF46, rd, ad, csd, rdd);
    check("t5_ff46_idle", rd, 8'hE2);

    // Reset at idx 80.
    push_copy(8'hC1, 80, 8'h5A);
    cpu_write(16'hFF46, 8'hC1);
    wait_pulse(8'd79);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_oam_wr", oam_wr, 1'b0);
    check("t6_dma_active", dma_active, 1'b0);
    check("t6_sb_empty", sb.size(), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cpu_read(16'hFF46, rd, ad, csd, rdd);
    check("t6_ff46", rd, 8'h00);
    @(negedge clk);
    A_up = 16'hC000; Di_up = 8'h99; cs_up = 1'b1; wr_up = 1'b1;
    #1;
    check("t6_pass_wr", {A_down, Do_down, cs_down, wr_down, rd_down}, {16'hC000, 8'h99, 3'b110});
    @(negedge clk);
    cs_up = 1'b0; wr_up = 1'b0;
    cpu_read(16'hC000, rd, ad, csd, rdd);
    check("t6_pass_rd", rd, 8'h99);

    repeat (10) @(negedge clk);
    check("total_pulses", pulses, 770);
    check("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
